// File: rtl/apb_slave_regs_if.sv
// APB3 bus bundle between the team's APB master FSM and the register-bank completer.
// The master modport drives the request side; the slave modport drives the response side.
interface apb_slave_regs_if;
   logic        i_psel;
   logic        i_penable;
   logic        i_pwrite;
   logic [31:0] i_paddr;
   logic [31:0] i_pwdata;
   logic        o_pready;
   logic [31:0] o_prdata;
   logic        o_pslverr;

   modport master (
      output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
      input  o_pready, o_prdata, o_pslverr
   );

   modport slave (
      input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
      output o_pready, o_prdata, o_pslverr
   );
endinterface

// File: rtl/apb_slave_regs.sv
// APB3 completer with NUM_REGS-1 read/write registers and a read-only hardware status word.
// It inserts WAIT_CYCLES wait states per access and raises PSLVERR on illegal accesses.
module apb_slave_regs #(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
   input  logic                   i_clk_apb,
   input  logic                   i_rst_apb,
   apb_slave_regs_if.slave        apb,
   input  logic [31:0]            i_status,
   output logic [NUM_REGS*32-1:0] o_reg_flat
);
   localparam int unsigned      IDX_W      = $clog2(NUM_REGS);
   localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(NUM_REGS - 1);
   localparam logic [31:0]      ADDR_LIMIT = 32'(NUM_REGS * 4);
   localparam logic [3:0]       WAIT_INIT  = 4'(WAIT_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [3:0]       cnt_q,     cnt_d;
   logic             wr_q,      wr_d;
   logic             err_q,     err_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [31:0]      wdata_q,   wdata_d;
   logic             pready_q,  pready_d;
   logic             pslverr_q, pslverr_d;
   logic [31:0]      prdata_q,  prdata_d;

   logic [IDX_W-1:0] dec_idx;
   logic             dec_err;
   logic             setup_seen;
   logic             enter_resp;
   logic             commit;
   logic [31:0]      rd_view [NUM_REGS];

   assign dec_idx    = apb.i_paddr[IDX_W+1:2];
   assign dec_err    = (apb.i_paddr >= ADDR_LIMIT) || (apb.i_paddr[1:0] != 2'b00)
                     || (apb.i_pwrite && (dec_idx == TOP_IDX));
   assign setup_seen = (state_q == S_IDLE) && apb.i_psel && !apb.i_penable;

   // A write lands only if the master is still in the access phase when RESP ends.
   assign commit = (state_q == S_RESP) && wr_q && !err_q && apb.i_psel && apb.i_penable;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_rw
         logic [31:0] rw_q;

         always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
            if (i_rst_apb) begin
               rw_q <= RESET_VAL;
            end else if (commit && (idx_q == IDX_W'(gi))) begin
               rw_q <= wdata_q;
            end
         end

         assign rd_view[gi] = rw_q;
      end

      for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign o_reg_flat[gi*32 +: 32] = rd_view[gi];
      end
   endgenerate

   assign rd_view[NUM_REGS-1] = i_status;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      err_d      = err_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (setup_seen) begin
               wr_d    = apb.i_pwrite;
               err_d   = dec_err;
               idx_d   = dec_idx;
               wdata_d = apb.i_pwdata;
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!apb.i_psel) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Response fields use the decode being latched this edge, which matters when WAIT_CYCLES is 0.
   always_comb begin
      pready_d  = enter_resp;
      pslverr_d = enter_resp && err_d;
      prdata_d  = (enter_resp && !wr_d && !err_d) ? rd_view[idx_d] : 32'h0;
   end

   always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
      if (i_rst_apb) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= 32'h0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign apb.o_pready  = pready_q;
   assign apb.o_pslverr = pslverr_q;
   assign apb.o_prdata  = prdata_q;
endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
- APB3 completer (responder) with a small register bank and programmable wait states.
- Answers transfers issued by the team's APB master FSM (setup phase, then access phase, extended while PREADY is low).
- Provides NUM_REGS-1 read/write 32-bit registers plus one read-only status word fed by hardware.
- Flags illegal accesses on PSLVERR.

Parameters:
- NUM_REGS, 16: register count, power of two, >=2. Index NUM_REGS-1 is the read-only status register.
- WAIT_CYCLES, 2: access-phase cycles with o_pready low before completion, range 0..15.
- RESET_VAL, 32'h0000_0000: reset value of every RW register.

Ports:
- i_clk_apb  in  1  APB clock; all logic on rising edge.
- i_rst_apb  in  1  asynchronous, active-high reset.
- i_psel  in  1  select.
- i_penable  in  1  access-phase enable.
- i_pwrite  in  1  1 = write, 0 = read.
- i_paddr  in  32  byte address.
- i_pwdata  in  32  write data.
- i_status  in  32  hardware status word, returned at the index NUM_REGS-1 address.
- o_pready  out  1  transfer completion.
- o_prdata  out  32  read data, valid while o_pready=1 on a read.
- o_pslverr  out  1  error, valid while o_pready=1.
- o_reg_flat  out  NUM_REGS*32  live RW register contents; index i at bits [32i+31:32i]; top slot mirrors i_status.

Behaviour:
- Reset values: state IDLE; o_pready=0, o_prdata=0, o_pslverr=0; RW registers = RESET_VAL; wait counter = 0. Reset is asynchronous and takes effect immediately, including mid-transfer; an aborted write never commits.
- All outputs are registered.
- Address decode:
  - idx = i_paddr[$clog2(NUM_REGS)+1:2].
  - err = (i_paddr >= NUM_REGS*4) | (i_paddr[1:0] != 0) | (write & idx == NUM_REGS-1).
  - Decode, write flag and wdata are latched at the setup-phase clock edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_pready=0.
  - On i_psel & !i_penable, latch the transfer. Go to WAIT with counter=WAIT_CYCLES, or to RESP if WAIT_CYCLES=0.
  - i_psel & i_penable seen in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - o_pready=0; counter decrements each cycle.
  - When counter==1 (or WAIT_CYCLES==0), the next state is RESP.
  - Net effect: exactly WAIT_CYCLES access cycles with o_pready low.
- Entering RESP (registered at the same edge):
  - o_pready=1 and o_pslverr=err.
  - o_prdata: for a legal read, reg[idx] (or i_status at the top index) sampled at that edge; 0 for writes and errors.
- RESP:
  - Lasts one cycle.
  - A write commits reg[idx]<=wdata at the edge ending RESP, only if the write is legal and i_psel & i_penable are still high.
  - Next state is IDLE; o_pready, o_pslverr and o_prdata return to 0.
  - A back-to-back setup phase on the next cycle is accepted from IDLE with no bubble beyond the APB setup cycle.
- Abort: i_psel low in WAIT or RESP sends the FSM to IDLE, clears the outputs and performs no write.
- An erroring write leaves all registers unchanged. An erroring read returns o_prdata=0.
- A read of the index being written in the same transfer is impossible (one transfer at a time). A read issued right after a write returns the new value.
- i_status is sampled only at RESP entry; no synchronisation (same clock domain).

Test Plan:
- WAIT_CYCLES=2, write 0x04 <= 0xDEADBEEF then read 0x04 -> each access shows 2 cycles o_pready=0 then 1 cycle o_pready=1; read o_prdata=0xDEADBEEF, o_pslverr=0; o_reg_flat[63:32]=0xDEADBEEF.
- Read 0x40 (out of range, NUM_REGS=16) and write 0x06 (unaligned) -> o_pslverr=1 with o_pready=1, o_prdata=0, no register changes.
- i_status=0xA5A5_0001: read 0x3C -> 0xA5A5_0001, no error; write 0x3C <= 0x1234 -> o_pslverr=1, readback still 0xA5A5_0001.
- WAIT_CYCLES=0, back-to-back writes 0x00=0x11 and 0x08=0x22 then reads -> o_pready high in the first access cycle each time; readbacks 0x11 and 0x22.
- Assert i_rst_apb during WAIT of a write 0x0C <= 0xFFFF_FFFF -> o_pready=0 immediately; reg 0x0C reads RESET_VAL after reset.
- Drop i_psel during WAIT of a write 0x10 <= 0x5555_5555 -> FSM returns to IDLE, no o_pready pulse, reg 0x10 unchanged.
